// File: rtl/fetch_pkg.sv
// Shared fetch types and decode field positions.
// The top's optional misalignment trap is enabled by FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} fetch_state_t;

  localparam int FETCH_XLEN = 32;
  localparam int PC_STEP    = 4;

  localparam int OP_HI = 6;
  localparam int OP_LO = 2;
  localparam int F3_HI = 14;
  localparam int F3_LO = 12;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  function automatic logic [OP_HI-OP_LO:0] instr_op(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [F3_HI-F3_LO:0] instr_f3(input logic [31:0] instr);
    return instr[F3_HI:F3_LO];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer; pointers carry an extra MSB so full/empty
// are distinguished without a separate counter.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  entry_t      wdata,
  output entry_t      rdata,
  output logic        empty,
  output logic [AW:0] count
);

  entry_t [DEPTH-1:0] mem;
  logic   [AW:0]      wptr, rptr;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Push onto a full buffer only happens alongside a pop of the same slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word fetches, buffers responses for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into HALT with a misalign_fault flag.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [31:0]     dec_instr,
  output logic [4:0]      dec_op,
  output logic [2:0]      dec_funct3
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } slot_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redir_tgt;
  logic [CW-1:0]   inflight, inflight_d, drop, drop_d, fifo_count;
  logic            accept, push, pop, fifo_empty, halted, bad_align;
  slot_t           head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_align = |redirect_pc[1:0];
  assign halted    = (state_q == HALT);
  assign redir_tgt = redirect_pc;

  always_ff @(posedge clk) begin
    if (rst)                 misalign_fault <= 1'b0;
    else if (redirect_valid) misalign_fault <= bad_align;
  end
`else
  assign bad_align = 1'b0;
  assign halted    = 1'b0;
  assign redir_tgt = redirect_pc & ~XLEN'(3);
`endif

  // Credit counts both outstanding fetches and buffered words so a response always has a slot.
  assign imem_req_valid = (state_q == RUN) && ((inflight + fifo_count) < CW'(FIFO_DEPTH))
                          && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign push      = imem_rsp_valid && !redirect_valid && (drop == '0) && !halted;
  assign dec_valid = !fifo_empty && !redirect_valid;
  assign pop       = dec_valid && dec_ready;

  assign dec_pc     = dec_valid ? head.pc    : '0;
  assign dec_instr  = dec_valid ? head.instr : '0;
  assign dec_op     = instr_op(dec_instr);
  assign dec_funct3 = instr_f3(dec_instr);

  always_comb begin
    inflight_d = inflight + CW'(accept) - CW'(imem_rsp_valid);
    drop_d     = drop;
    if (redirect_valid)
      drop_d = inflight_d;
    else if (imem_rsp_valid && drop != '0)
      drop_d = drop - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redirect_valid && inflight_d != '0) state_d = DRAIN;
      DRAIN:   if (!redirect_valid && drop_d == '0) state_d = RUN;
      default: ;
    endcase
    if (redirect_valid && bad_align)
      state_d = HALT;
    else if (redirect_valid && state_q == HALT)
      state_d = (inflight_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= inflight_d;
      drop     <= drop_d;
      if (redirect_valid) begin
        fetch_pc <= redir_tgt;
        rsp_pc   <= redir_tgt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (push)   rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .entry_t (slot_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ('{pc: rsp_pc, instr: imem_rsp_data}),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder plus a PC-stream model of
// what decode and memory must see; directed scenarios pin the model with literals.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_instr;
  logic [4:0]  dec_op;
  logic [2:0]  dec_funct3;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_instr(dec_instr), .dec_op(dec_op), .dec_funct3(dec_funct3)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_fault(misalign_fault)
`endif
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hDEAD_BEEF;
  endfunction

  // Memory: in-order, latency drawn from [lat_lo, lat_hi] cycles after accept.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc    = 0;
  int    lat_lo = 1;
  int    lat_hi = 1;

  initial begin
    logic rst_s;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      if (rst_s) mq.delete();
      else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  end

  // Model: after reset/redirect to T, memory sees T, T+4, ... and so does decode.
  logic [31:0] exp_req, exp_dec, held_pc, held_instr;
  logic        held, halted_m;
  int          acc_cnt;
  logic [31:0] pc_log[$], instr_log[$], acc_log[$];
  logic [4:0]  op_log[$];
  logic [2:0]  f3_log[$];

  initial begin
    exp_req = '0; exp_dec = '0; held = 1'b0; halted_m = 1'b0; acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_req = '0; exp_dec = '0; held = 1'b0; halted_m = 1'b0;
        continue;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check("fault_flag", misalign_fault, halted_m);
      if (halted_m && !redirect_valid) begin
        check("halt_no_req", imem_req_valid, 1'b0);
        check("halt_no_dec", dec_valid, 1'b0);
      end
`endif
      if (redirect_valid) begin
        check("redir_no_req", imem_req_valid, 1'b0);
        check("redir_no_dec", dec_valid, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        halted_m = (redirect_pc[1:0] != 2'b00);
`endif
        exp_req = redirect_pc & ~32'h3;
        exp_dec = redirect_pc & ~32'h3;
        held    = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", dec_valid, 1'b1);
          check("hold_pc", dec_pc, held_pc);
          check("hold_instr", dec_instr, held_instr);
        end
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_req);
          mq.push_back('{imem_req_addr, cyc + $urandom_range(lat_hi, lat_lo)});
          acc_log.push_back(imem_req_addr);
          acc_cnt++;
          exp_req += 32'd4;
        end
        if (dec_valid && dec_ready) begin
          check("dec_pc", dec_pc, exp_dec);
          check("dec_instr", dec_instr, mem_word(exp_dec));
          check("dec_op", dec_op, dec_instr[6:2]);
          check("dec_funct3", dec_funct3, dec_instr[14:12]);
          pc_log.push_back(dec_pc);
          instr_log.push_back(dec_instr);
          op_log.push_back(dec_op);
          f3_log.push_back(dec_funct3);
          exp_dec += 32'd4;
        end
        held       = dec_valid && !dec_ready;
        held_pc    = dec_pc;
        held_instr = dec_instr;
      end
      check("inflight_bound", (mq.size() <= DEPTH), 1'b1);
    end
  end

  task automatic clear_logs();
    pc_log.delete(); instr_log.delete(); op_log.delete(); f3_log.delete(); acc_log.delete();
    acc_cnt = 0;
  endtask

  task automatic redirect(input logic [31:0] t);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    clear_logs();
  endtask

  task automatic wait_dec(input int n, input string name);
    for (int i = 0; i < 300 && pc_log.size() < n; i++) @(posedge clk);
    check(name, (pc_log.size() >= n), 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_req_addr"},  imem_req_addr, 32'h0);
    check({tag, "_dec_valid"}, dec_valid, 1'b0);
    check({tag, "_dec_pc"},    dec_pc, 32'h0);
    check({tag, "_dec_instr"}, dec_instr, 32'h0);
    check({tag, "_dec_op"},    dec_op, 5'h0);
    check({tag, "_dec_f3"},    dec_funct3, 3'h0);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset");
`ifdef FETCH_MISALIGN_TRAP_EN
    check("reset_fault", misalign_fault, 1'b0);
`endif
    rst = 1'b0;
    clear_logs();

    // 1: stream from RESET_PC
    wait_dec(3, "t1_reached");
    if (pc_log.size() >= 3) begin
      check("t1_first_req", acc_log[0], 32'h0);
      check("t1_pc0", pc_log[0], 32'h0);
      check("t1_pc1", pc_log[1], 32'h4);
      check("t1_pc2", pc_log[2], 32'h8);
      check("t1_instr0", instr_log[0], 32'hDEAD_BEEF);
      check("t1_op0", op_log[0], 5'h1B);
      check("t1_f3_0", f3_log[0], 3'h3);
    end

    // 2: decode stalled 10 cycles after a restart -> only FIFO_DEPTH fetches
    @(posedge clk); #1; dec_ready = 1'b0;
    redirect(32'h40);
    repeat (10) @(posedge clk);
    #1;
    check("t2_accepts", acc_cnt, DEPTH);
    check("t2_valid", dec_valid, 1'b1);
    check("t2_head", dec_pc, 32'h40);
    dec_ready = 1'b1;
    wait_dec(3, "t2_reached");
    if (pc_log.size() >= 3) begin
      check("t2_pc0", pc_log[0], 32'h40);
      check("t2_pc2", pc_log[2], 32'h48);
    end

    // 3: redirect with two fetches outstanding
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 50 && mq.size() < 2; i++) @(posedge clk);
    check("t3_two_inflight", mq.size(), 2);
    redirect(32'h100);
    lat_lo = 1; lat_hi = 1;
    wait_dec(2, "t3_reached");
    if (pc_log.size() >= 2) begin
      check("t3_pc0", pc_log[0], 32'h100);
      check("t3_pc1", pc_log[1], 32'h104);
    end

    // 4: redirect in a cycle with a response and a presented instruction
    begin
      logic hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
        @(posedge clk); #2;
        hit = imem_rsp_valid && dec_valid;
      end
      check("t4_window_found", hit, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      clear_logs();
    end
    wait_dec(1, "t4_reached");
    if (acc_log.size() >= 1) check("t4_next_req", acc_log[0], 32'h100);
    if (pc_log.size() >= 1) check("t4_pc0", pc_log[0], 32'h100);

    // 5: address wrap at the top of the space
    redirect(32'hFFFF_FFF8);
    wait_dec(4, "t5_reached");
    if (pc_log.size() >= 4) begin
      check("t5_pc1", pc_log[1], 32'hFFFF_FFFC);
      check("t5_pc2", pc_log[2], 32'h0);
      check("t5_pc3", pc_log[3], 32'h4);
      check("t5_req2", acc_log[2], 32'h0);
    end

    // 6: misaligned redirect
    redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (5) @(posedge clk);
    #1;
    check("t6_fault", misalign_fault, 1'b1);
    check("t6_req_off", imem_req_valid, 1'b0);
    check("t6_dec_off", dec_valid, 1'b0);
    redirect(32'h200);
    check("t6_fault_clr", misalign_fault, 1'b0);
`else
    wait_dec(2, "t6_aligned_reached");
    if (pc_log.size() >= 2) begin
      check("t6_pc0", pc_log[0], 32'h100);
      check("t6_pc1", pc_log[1], 32'h104);
    end
    redirect(32'h200);
`endif
    wait_dec(2, "t6_resume");
    if (pc_log.size() >= 2) begin
      check("t6_pc200", pc_log[0], 32'h200);
      check("t6_pc204", pc_log[1], 32'h204);
    end

    // 7: mixed latency, back-pressure and redirects, checked by the model
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      dec_ready      = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(4, 0) != 0);
      redirect_valid = (i % 70 == 35);
      redirect_pc    = {$urandom_range(32'hFFFF, 0), 16'h0} | 32'(($urandom_range(63, 0)) * 4);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;

    // mid-operation reset
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    lat_lo = 1; lat_hi = 1;
    clear_logs();
    wait_dec(2, "rst_resume");
    if (pc_log.size() >= 2) begin
      check("rst_pc0", pc_log[0], 32'h0);
      check("rst_pc1", pc_log[1], 32'h4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
